// File: rtl/stroke_pkg.sv
// Shared types and canvas constants for the stroke rasteriser.
// Contents:
//   CANVAS_H / CANVAS_V - canvas size in scaled pixels
//   PKG_*_W             - default field widths; each coordinate width has one
//                         spare bit so that off-canvas positions can still be
//                         expressed and then clipped
//   stamp_t             - one brush stamp {x, y, color, sw}
//   state_t             - painter FSM state
package stroke_pkg;

    localparam int CANVAS_H    = 320;
    localparam int CANVAS_V    = 180;
    localparam int PKG_X_W     = $clog2(CANVAS_H) + 1;
    localparam int PKG_Y_W     = $clog2(CANVAS_V) + 1;
    localparam int PKG_COLOR_W = 4;
    localparam int PKG_SW_W    = 3;
    localparam int PKG_ADDR_W  = 16;

    typedef struct packed {
        logic [PKG_X_W-1:0]     x;
        logic [PKG_Y_W-1:0]     y;
        logic [PKG_COLOR_W-1:0] color;
        logic [PKG_SW_W-1:0]    sw;
    } stamp_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_PAINT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for the stroke source channels.
// Ports:
//   clk_in, rst_in  - clock, synchronous active-high reset
//   req_in          - per-channel request
//   accept_in       - strobe: the current grant was taken this cycle
//   grant_out       - one-hot grant, combinational from req_in and pointer
//   grant_idx_out   - binary index of the granted channel (0 when no grant)
// The search starts at the pointer and wraps; after an accepted grant the
// pointer moves to the channel just past the winner, so every requester is
// reached within NUM_CH grants.
module rr_arbiter #(
    parameter int NUM_CH = 2,
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [NUM_CH-1:0] req_in,
    input  logic              accept_in,
    output logic [NUM_CH-1:0] grant_out,
    output logic [PTR_W-1:0]  grant_idx_out
);

    localparam logic [PTR_W:0]   NUM_CH_L = (PTR_W + 1)'(NUM_CH);
    localparam logic [PTR_W-1:0] LAST_CH  = PTR_W'(NUM_CH - 1);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        grant_out     = '0;
        grant_idx_out = '0;
        found         = 1'b0;
        sum           = '0;
        idx           = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            sum = {1'b0, ptr_q} + (PTR_W + 1)'(k);
            if (sum >= NUM_CH_L) begin
                sum = sum - NUM_CH_L;
            end
            idx = sum[PTR_W-1:0];
            if (!found && req_in[idx]) begin
                found          = 1'b1;
                grant_out[idx] = 1'b1;
                grant_idx_out  = idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept_in) begin
            ptr_d = (grant_idx_out == LAST_CH) ? '0 : grant_idx_out + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/stroke_rasteriser.sv
// N-channel stroke painter: arbitrates between stamp sources and expands each
// accepted stamp into a clipped (sw+1)x(sw+1) square of frame-buffer writes.
// Ports:
//   clk_in, rst_in      - pixel clock, synchronous active-high reset
//   ch_valid_in         - per-channel stamp request
//   ch_x/y/color/sw_in  - packed per-channel stamp fields, channel i at [i*W +: W]
//   ch_ready_out        - one-hot accept, only asserted in IDLE
//   wr_valid_out        - pixel write valid (registered)
//   wr_ready_in         - canvas accepts the write
//   wr_addr_out         - y*H_MAX + x of the pixel
//   wr_color_out        - pixel color
//   busy_out            - high while painting
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | arbitrate; accept one stamp per cycle, drop duplicates here
// ST_PAINT | walk the brush square row-major, one pixel slot per cycle
module stroke_rasteriser
    import stroke_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int X_W     = PKG_X_W,
    parameter int Y_W     = PKG_Y_W,
    parameter int COLOR_W = PKG_COLOR_W,
    parameter int SW_W    = PKG_SW_W,
    parameter int H_MAX   = CANVAS_H,
    parameter int V_MAX   = CANVAS_V,
    parameter int ADDR_W  = PKG_ADDR_W
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [NUM_CH-1:0]         ch_valid_in,
    input  logic [NUM_CH*X_W-1:0]     ch_x_in,
    input  logic [NUM_CH*Y_W-1:0]     ch_y_in,
    input  logic [NUM_CH*COLOR_W-1:0] ch_color_in,
    input  logic [NUM_CH*SW_W-1:0]    ch_sw_in,
    output logic [NUM_CH-1:0]         ch_ready_out,
    output logic                      wr_valid_out,
    input  logic                      wr_ready_in,
    output logic [ADDR_W-1:0]         wr_addr_out,
    output logic [COLOR_W-1:0]        wr_color_out,
    output logic                      busy_out
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_MAX);
    localparam logic [X_W:0]      H_LIM  = (X_W + 1)'(H_MAX);
    localparam logic [Y_W:0]      V_LIM  = (Y_W + 1)'(V_MAX);

    logic [NUM_CH-1:0] grant;
    logic [PTR_W-1:0]  gidx;
    logic              transfer;

    state_t               state_q,     state_d;
    logic [X_W-1:0]       x_q,         x_d;
    logic [Y_W-1:0]       y_q,         y_d;
    logic [COLOR_W-1:0]   color_q,     color_d;
    logic [SW_W-1:0]      sw_q,        sw_d;
    logic [SW_W-1:0]      dx_q,        dx_d;
    logic [SW_W-1:0]      dy_q,        dy_d;
    logic [ADDR_W-1:0]    row_base_q,  row_base_d;
    logic                 wr_valid_q,  wr_valid_d;
    logic [ADDR_W-1:0]    wr_addr_q,   wr_addr_d;
    logic [COLOR_W-1:0]   wr_color_q,  wr_color_d;
    logic [NUM_CH-1:0]    last_vld_q,  last_vld_d;
    logic [X_W-1:0]       last_x_q     [NUM_CH];
    logic [X_W-1:0]       last_x_d     [NUM_CH];
    logic [Y_W-1:0]       last_y_q     [NUM_CH];
    logic [Y_W-1:0]       last_y_d     [NUM_CH];
    logic [COLOR_W-1:0]   last_color_q [NUM_CH];
    logic [COLOR_W-1:0]   last_color_d [NUM_CH];
    logic [SW_W-1:0]      last_sw_q    [NUM_CH];
    logic [SW_W-1:0]      last_sw_d    [NUM_CH];

    logic [X_W-1:0]     sel_x;
    logic [Y_W-1:0]     sel_y;
    logic [COLOR_W-1:0] sel_color;
    logic [SW_W-1:0]    sel_sw;
    logic               dup;
    logic [SW_W-1:0]    nx;
    logic [SW_W-1:0]    ny;
    logic [ADDR_W-1:0]  nrow;
    logic [X_W:0]       px;
    logic [Y_W:0]       py;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .req_in        (ch_valid_in),
        .accept_in     (transfer),
        .grant_out     (grant),
        .grant_idx_out (gidx)
    );

    // Ready is masked during reset so nothing is taken while state is forced.
    assign ch_ready_out = (state_q == ST_IDLE && !rst_in) ? grant : '0;
    assign transfer     = |ch_ready_out;

    assign wr_valid_out = wr_valid_q;
    assign wr_addr_out  = wr_addr_q;
    assign wr_color_out = wr_color_q;
    assign busy_out     = (state_q != ST_IDLE);

    always_comb begin
        sel_x     = '0;
        sel_y     = '0;
        sel_color = '0;
        sel_sw    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                sel_x     = ch_x_in[i*X_W +: X_W];
                sel_y     = ch_y_in[i*Y_W +: Y_W];
                sel_color = ch_color_in[i*COLOR_W +: COLOR_W];
                sel_sw    = ch_sw_in[i*SW_W +: SW_W];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        color_d      = color_q;
        sw_d         = sw_q;
        dx_d         = dx_q;
        dy_d         = dy_q;
        row_base_d   = row_base_q;
        wr_valid_d   = wr_valid_q;
        wr_addr_d    = wr_addr_q;
        wr_color_d   = wr_color_q;
        last_vld_d   = last_vld_q;
        last_x_d     = last_x_q;
        last_y_d     = last_y_q;
        last_color_d = last_color_q;
        last_sw_d    = last_sw_q;
        dup          = 1'b0;
        nx           = '0;
        ny           = '0;
        nrow         = '0;
        px           = '0;
        py           = '0;

        case (state_q)
            ST_IDLE: begin
                wr_valid_d = 1'b0;
                if (transfer) begin
                    dup = last_vld_q[gidx]
                        && last_x_q[gidx]     == sel_x
                        && last_y_q[gidx]     == sel_y
                        && last_color_q[gidx] == sel_color
                        && last_sw_q[gidx]    == sel_sw;
                    if (!dup) begin
                        last_vld_d[gidx]   = 1'b1;
                        last_x_d[gidx]     = sel_x;
                        last_y_d[gidx]     = sel_y;
                        last_color_d[gidx] = sel_color;
                        last_sw_d[gidx]    = sel_sw;
                        state_d    = ST_PAINT;
                        x_d        = sel_x;
                        y_d        = sel_y;
                        color_d    = sel_color;
                        sw_d       = sel_sw;
                        dx_d       = '0;
                        dy_d       = '0;
                        // The only multiply: seeds the row base once per stamp.
                        row_base_d = ADDR_W'(sel_y) * H_STEP;
                        wr_addr_d  = row_base_d + ADDR_W'(sel_x);
                        wr_color_d = sel_color;
                        wr_valid_d = ({1'b0, sel_x} < H_LIM) && ({1'b0, sel_y} < V_LIM);
                    end
                end
            end

            ST_PAINT: begin
                // A clipped slot has valid low and so always advances.
                if (!wr_valid_q || wr_ready_in) begin
                    if (dx_q == sw_q && dy_q == sw_q) begin
                        state_d    = ST_IDLE;
                        wr_valid_d = 1'b0;
                    end else begin
                        if (dx_q == sw_q) begin
                            nx   = '0;
                            ny   = dy_q + 1'b1;
                            nrow = row_base_q + H_STEP;
                        end else begin
                            nx   = dx_q + 1'b1;
                            ny   = dy_q;
                            nrow = row_base_q;
                        end
                        px         = {1'b0, x_q} + (X_W + 1)'(nx);
                        py         = {1'b0, y_q} + (Y_W + 1)'(ny);
                        dx_d       = nx;
                        dy_d       = ny;
                        row_base_d = nrow;
                        wr_addr_d  = nrow + ADDR_W'(px);
                        wr_valid_d = (px < H_LIM) && (py < V_LIM);
                    end
                end
            end

            default: begin
                state_d    = ST_IDLE;
                wr_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            color_q    <= '0;
            sw_q       <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            row_base_q <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_color_q <= '0;
            last_vld_q <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            color_q      <= color_d;
            sw_q         <= sw_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            row_base_q   <= row_base_d;
            wr_valid_q   <= wr_valid_d;
            wr_addr_q    <= wr_addr_d;
            wr_color_q   <= wr_color_d;
            last_vld_q   <= last_vld_d;
            last_x_q     <= last_x_d;
            last_y_q     <= last_y_d;
            last_color_q <= last_color_d;
            last_sw_q    <= last_sw_d;
        end
    end

endmodule

// File: tb/tb_stroke_rasteriser.sv
// Directed bench for stroke_rasteriser: reset values, single-pixel latency,
// row-major brush order, clipping at the canvas corner, round-robin grants,
// duplicate suppression, write backpressure and reset in the middle of a stamp.
module tb_stroke_rasteriser;
    import stroke_pkg::*;

    localparam int NUM_CH  = 2;
    localparam int X_W     = PKG_X_W;
    localparam int Y_W     = PKG_Y_W;
    localparam int COLOR_W = PKG_COLOR_W;
    localparam int SW_W    = PKG_SW_W;
    localparam int ADDR_W  = PKG_ADDR_W;

    logic                      clk_in = 1'b0;
    logic                      rst_in;
    logic [NUM_CH-1:0]         ch_valid_in;
    logic [NUM_CH*X_W-1:0]     ch_x_in;
    logic [NUM_CH*Y_W-1:0]     ch_y_in;
    logic [NUM_CH*COLOR_W-1:0] ch_color_in;
    logic [NUM_CH*SW_W-1:0]    ch_sw_in;
    logic [NUM_CH-1:0]         ch_ready_out;
    logic                      wr_valid_out;
    logic                      wr_ready_in;
    logic [ADDR_W-1:0]         wr_addr_out;
    logic [COLOR_W-1:0]        wr_color_out;
    logic                      busy_out;

    int n_vec = 0;
    int n_bad = 0;

    int wa_q[$];
    int wc_q[$];
    int ea_q[$];
    int ec_q[$];

    stroke_rasteriser #(
        .NUM_CH (NUM_CH), .X_W (X_W), .Y_W (Y_W), .COLOR_W (COLOR_W),
        .SW_W (SW_W), .H_MAX (320), .V_MAX (180), .ADDR_W (ADDR_W)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .ch_valid_in  (ch_valid_in),
        .ch_x_in      (ch_x_in),
        .ch_y_in      (ch_y_in),
        .ch_color_in  (ch_color_in),
        .ch_sw_in     (ch_sw_in),
        .ch_ready_out (ch_ready_out),
        .wr_valid_out (wr_valid_out),
        .wr_ready_in  (wr_ready_in),
        .wr_addr_out  (wr_addr_out),
        .wr_color_out (wr_color_out),
        .busy_out     (busy_out)
    );

    always #5 clk_in = ~clk_in;

    // Accepted writes; valid/ready are stable from mid-cycle to the next edge.
    always @(negedge clk_in) begin
        if (!rst_in && wr_valid_out && wr_ready_in) begin
            wa_q.push_back(int'(wr_addr_out));
            wc_q.push_back(int'(wr_color_out));
        end
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic stamp_t mk(input int x, input int y, input int c, input int s);
        stamp_t st;
        st.x     = x[X_W-1:0];
        st.y     = y[Y_W-1:0];
        st.color = c[COLOR_W-1:0];
        st.sw    = s[SW_W-1:0];
        return st;
    endfunction

    // Reference: direct y*320+x per pixel, row-major, clipped.
    function automatic void model(input stamp_t st);
        for (int dy = 0; dy <= int'(st.sw); dy++) begin
            for (int dx = 0; dx <= int'(st.sw); dx++) begin
                int px = int'(st.x) + dx;
                int py = int'(st.y) + dy;
                if (px < 320 && py < 180) begin
                    ea_q.push_back(py * 320 + px);
                    ec_q.push_back(int'(st.color));
                end
            end
        end
    endfunction

    function automatic void clear_q();
        wa_q.delete();
        wc_q.delete();
        ea_q.delete();
        ec_q.delete();
    endfunction

    task automatic check_writes(input string tag);
        check_val({tag, "_count"}, wa_q.size(), ea_q.size());
        for (int i = 0; i < ea_q.size() && i < wa_q.size(); i++) begin
            check_val({tag, "_addr"}, wa_q[i], ea_q[i]);
            check_val({tag, "_color"}, wc_q[i], ec_q[i]);
        end
        clear_q();
    endtask

    task automatic drive_ch(input int ch, input stamp_t st);
        ch_x_in[ch*X_W +: X_W]             = st.x;
        ch_y_in[ch*Y_W +: Y_W]             = st.y;
        ch_color_in[ch*COLOR_W +: COLOR_W] = st.color;
        ch_sw_in[ch*SW_W +: SW_W]          = st.sw;
    endtask

    // Entered and left just after a rising edge.
    task automatic send(input int ch, input stamp_t st);
        bit got = 1'b0;
        drive_ch(ch, st);
        ch_valid_in[ch] = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk_in);
            if (ch_ready_out[ch]) got = 1'b1;
            @(posedge clk_in);
            #1;
        end
        ch_valid_in[ch] = 1'b0;
        check_val("grant", int'(got), 1);
    endtask

    task automatic wait_idle(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk_in);
            if (!busy_out && !wr_valid_out) done = 1'b1;
        end
        check_val({tag, "_idle"}, int'(done), 1);
        @(posedge clk_in);
        #1;
    endtask

    task automatic pulse_reset(input int cycles);
        rst_in = 1'b1;
        repeat (cycles) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        stamp_t st;
        stamp_t s0;
        stamp_t s1;
        int     t2_addr [9] = '{16100, 16101, 16102, 16420, 16421, 16422, 16740, 16741, 16742};
        int     exp_g [4]   = '{0, 1, 0, 1};
        int     gseq[$];
        bit     pat [4]     = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [NUM_CH-1:0] g;
        bit     prev_stall;
        int     prev_addr;
        int     prev_color;
        int     cyc_busy;

        // Reset with a request pending: nothing may be accepted.
        rst_in      = 1'b1;
        ch_valid_in = 2'b01;
        ch_x_in     = '0;
        ch_y_in     = '0;
        ch_color_in = '0;
        ch_sw_in    = '0;
        wr_ready_in = 1'b1;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check_val("rst_wr_valid", int'(wr_valid_out), 0);
        check_val("rst_wr_addr", int'(wr_addr_out), 0);
        check_val("rst_wr_color", int'(wr_color_out), 0);
        check_val("rst_busy", int'(busy_out), 0);
        check_val("rst_ready", int'(ch_ready_out), 0);
        @(posedge clk_in);
        #1;
        rst_in      = 1'b0;
        ch_valid_in = '0;

        // Single pixel, cycle-exact latency.
        st = mk(10, 20, 5, 0);
        drive_ch(0, st);
        ch_valid_in[0] = 1'b1;
        @(negedge clk_in);
        check_val("t1_ready", int'(ch_ready_out), 1);
        check_val("t1_busy_T", int'(busy_out), 0);
        @(posedge clk_in);
        #1;
        ch_valid_in[0] = 1'b0;
        @(negedge clk_in);
        check_val("t1_valid_T1", int'(wr_valid_out), 1);
        check_val("t1_addr_T1", int'(wr_addr_out), 6410);
        check_val("t1_color_T1", int'(wr_color_out), 5);
        check_val("t1_busy_T1", int'(busy_out), 1);
        @(negedge clk_in);
        check_val("t1_valid_T2", int'(wr_valid_out), 0);
        check_val("t1_busy_T2", int'(busy_out), 0);
        @(posedge clk_in);
        #1;
        model(st);
        check_writes("t1");

        // 3x3 brush, row-major.
        send(0, mk(100, 50, 7, 2));
        wait_idle("t2");
        check_val("t2_count", wa_q.size(), 9);
        for (int i = 0; i < 9 && i < wa_q.size(); i++) begin
            check_val("t2_addr", wa_q[i], t2_addr[i]);
            check_val("t2_color", wc_q[i], 7);
        end
        clear_q();

        // Bottom-right corner: one write, three clipped slots.
        send(0, mk(319, 179, 12, 1));
        cyc_busy = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_in);
            if (!busy_out) break;
            cyc_busy++;
        end
        check_val("t3_paint_len", cyc_busy, 4);
        @(posedge clk_in);
        #1;
        check_val("t3_count", wa_q.size(), 1);
        if (wa_q.size() > 0) check_val("t3_addr", wa_q[0], 57599);
        clear_q();

        // Both channels requesting continuously with moving stamps.
        pulse_reset(2);
        s0 = mk(10, 30, 2, 0);
        s1 = mk(200, 40, 6, 0);
        drive_ch(0, s0);
        drive_ch(1, s1);
        ch_valid_in = 2'b11;
        for (int cyc = 0; cyc < 100 && gseq.size() < 4; cyc++) begin
            @(negedge clk_in);
            g = ch_ready_out;
            if (g[0]) begin
                gseq.push_back(0);
                model(s0);
            end
            if (g[1]) begin
                gseq.push_back(1);
                model(s1);
            end
            @(posedge clk_in);
            #1;
            if (gseq.size() < 4) begin
                if (g[0]) begin
                    s0.x = s0.x + 10'd5;
                    drive_ch(0, s0);
                end
                if (g[1]) begin
                    s1.x = s1.x + 10'd5;
                    drive_ch(1, s1);
                end
            end
        end
        ch_valid_in = '0;
        wait_idle("t4");
        check_val("t4_grants", gseq.size(), 4);
        for (int i = 0; i < 4 && i < gseq.size(); i++) begin
            check_val("t4_grant_seq", gseq[i], exp_g[i]);
        end
        check_writes("t4");

        // Re-present ch1's last stamp: accepted, no writes, never busy.
        send(1, s1);
        @(negedge clk_in);
        check_val("t4_dup_busy", int'(busy_out), 0);
        check_val("t4_dup_valid", int'(wr_valid_out), 0);
        @(posedge clk_in);
        #1;
        wait_idle("t4_dup");
        check_writes("t4_dup");

        // Backpressure: ready pattern 1,0,0,1 repeating from the first pixel.
        st = mk(50, 60, 9, 1);
        model(st);
        drive_ch(0, st);
        ch_valid_in[0] = 1'b1;
        @(negedge clk_in);
        check_val("t5_ready", int'(ch_ready_out), 1);
        prev_stall = 1'b0;
        prev_addr  = 0;
        prev_color = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_in);
            #1;
            ch_valid_in[0] = 1'b0;
            wr_ready_in    = pat[i % 4];
            @(negedge clk_in);
            if (prev_stall) begin
                check_val("t5_hold_valid", int'(wr_valid_out), 1);
                check_val("t5_hold_addr", int'(wr_addr_out), prev_addr);
                check_val("t5_hold_color", int'(wr_color_out), prev_color);
            end
            prev_stall = wr_valid_out && !wr_ready_in;
            prev_addr  = int'(wr_addr_out);
            prev_color = int'(wr_color_out);
            if (!busy_out) break;
        end
        check_val("t5_done", int'(busy_out), 0);
        @(posedge clk_in);
        #1;
        wr_ready_in = 1'b1;
        check_writes("t5");

        // Reset while the third pixel is presented, then resend the same stamp.
        pulse_reset(2);
        st = mk(100, 50, 3, 2);
        drive_ch(0, st);
        ch_valid_in[0] = 1'b1;
        @(negedge clk_in);
        check_val("t6_ready", int'(ch_ready_out), 1);
        @(posedge clk_in);
        #1;
        ch_valid_in[0] = 1'b0;
        @(posedge clk_in);
        #1;
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        @(negedge clk_in);
        check_val("t6_pix3_valid", int'(wr_valid_out), 1);
        check_val("t6_pix3_addr", int'(wr_addr_out), 16102);
        @(negedge clk_in);
        check_val("t6_rst_valid", int'(wr_valid_out), 0);
        check_val("t6_rst_busy", int'(busy_out), 0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        check_val("t6_partial_count", wa_q.size(), 2);
        clear_q();
        send(0, st);
        wait_idle("t6");
        model(st);
        check_writes("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
